// File: rtl/bp_predictor.sv
`default_nettype none
// ============================================================================
// Module  : bp_predictor
// Brief   : 2-bit counter PHT + direct-mapped BTB with a registered 37-bit
//           prediction record (write-first bypass on same-index updates).
// Rev     : 1.0  initial release
// ============================================================================
module bp_predictor #(
  parameter int PHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_lookup_valid,
  input  logic [31:0] fs_lookup_pc,
  input  logic        fs_stall,
  input  logic        pht_we,
  input  logic [31:0] pht_pc,
  input  logic [1:0]  pht_state,
  input  logic        btb_we,
  input  logic [31:0] btb_pc,
  input  logic [31:0] btb_target,
  output logic        predict_valid,
  output logic        predict_taken,
  output logic [1:0]  predict_state,
  output logic        btb_hit,
  output logic [31:0] predict_target,
  output logic [36:0] bp_info
);

  localparam int          PHT_N  = 1 << PHT_IDX_W;
  localparam int          BTB_N  = 1 << BTB_IDX_W;
  localparam int          TAG_W  = 30 - BTB_IDX_W;
  localparam logic [1:0]  C_WNT  = 2'b01;

  logic [1:0]       r_pht     [PHT_N];
  logic [BTB_N-1:0] r_btb_vld;
  logic [TAG_W-1:0] r_btb_tag [BTB_N];
  logic [31:0]      r_btb_tgt [BTB_N];
  logic [36:0]      r_info;

  logic [PHT_IDX_W-1:0] w_pht_idx, w_pht_widx;
  logic [BTB_IDX_W-1:0] w_btb_idx, w_btb_widx;
  logic [TAG_W-1:0]     w_tag, w_wtag, w_btag;
  logic [1:0]           w_state;
  logic                 w_bvld, w_hit, w_taken;
  logic [31:0]          w_btgt, w_seq, w_target;
  logic                 w_unused;

  assign w_pht_idx  = fs_lookup_pc[PHT_IDX_W+1:2];
  assign w_pht_widx = pht_pc[PHT_IDX_W+1:2];
  assign w_btb_idx  = fs_lookup_pc[BTB_IDX_W+1:2];
  assign w_btb_widx = btb_pc[BTB_IDX_W+1:2];
  assign w_tag      = fs_lookup_pc[31:BTB_IDX_W+2];
  assign w_wtag     = btb_pc[31:BTB_IDX_W+2];
  assign w_unused   = ^{pht_pc[31:PHT_IDX_W+2], pht_pc[1:0], btb_pc[1:0], fs_lookup_pc[1:0]};

  // Same-cycle writes to the looked-up index win over the stored entry.
  always_comb begin
    w_state = r_pht[w_pht_idx];
    w_bvld  = r_btb_vld[w_btb_idx];
    w_btag  = r_btb_tag[w_btb_idx];
    w_btgt  = r_btb_tgt[w_btb_idx];
    if (pht_we && (w_pht_widx == w_pht_idx)) begin
      w_state = pht_state;
    end
    if (btb_we && (w_btb_widx == w_btb_idx)) begin
      w_bvld = 1'b1;
      w_btag = w_wtag;
      w_btgt = btb_target;
    end
    w_hit    = w_bvld && (w_btag == w_tag);
    w_taken  = w_state[1] & w_hit;
    w_seq    = {fs_lookup_pc[31:2], 2'b00} + 32'd4;
    w_target = w_taken ? w_btgt : w_seq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht[i] <= C_WNT;
      end
      r_btb_vld <= '0;
    end else begin
      if (pht_we) begin
        r_pht[w_pht_widx] <= pht_state;
      end
      if (btb_we) begin
        r_btb_vld[w_btb_widx] <= 1'b1;
        r_btb_tag[w_btb_widx] <= w_wtag;
        r_btb_tgt[w_btb_widx] <= btb_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_info <= '0;
    end else if (!fs_stall) begin
      r_info <= fs_lookup_valid ? {1'b1, w_taken, w_state, w_hit, w_target} : 37'h0;
    end
  end

  assign bp_info        = r_info;
  assign predict_valid  = r_info[36];
  assign predict_taken  = r_info[35];
  assign predict_state  = r_info[34:33];
  assign btb_hit        = r_info[32];
  assign predict_target = r_info[31:0];

endmodule
`default_nettype wire

// File: tb/tb_bp_predictor.sv
`default_nettype none
// Testbench for bp_predictor: table-level reference model compared every cycle,
// plus directed vectors with hand-computed prediction records.
module tb_bp_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_lookup_valid;
  logic [31:0] fs_lookup_pc;
  logic        fs_stall;
  logic        pht_we;
  logic [31:0] pht_pc;
  logic [1:0]  pht_state;
  logic        btb_we;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        predict_valid, predict_taken, btb_hit;
  logic [1:0]  predict_state;
  logic [31:0] predict_target;
  logic [36:0] bp_info;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bp_predictor #(.PHT_IDX_W(6), .BTB_IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .fs_lookup_valid(fs_lookup_valid), .fs_lookup_pc(fs_lookup_pc), .fs_stall(fs_stall),
    .pht_we(pht_we), .pht_pc(pht_pc), .pht_state(pht_state),
    .btb_we(btb_we), .btb_pc(btb_pc), .btb_target(btb_target),
    .predict_valid(predict_valid), .predict_taken(predict_taken),
    .predict_state(predict_state), .btb_hit(btb_hit),
    .predict_target(predict_target), .bp_info(bp_info)
  );

  // Reference model: 64 counters, 16 BTB entries, indexed by word address.
  int unsigned m_pht  [64];
  bit          m_bv   [16];
  int unsigned m_btag [16];
  int unsigned m_btgt [16];
  logic [36:0] m_exp;
  bit          m_live = 1'b0;

  function automatic logic [36:0] predict(input int unsigned pc);
    int unsigned pi, bi, st, tgt;
    bit hit, tk;
    pi  = (pc / 4) % 64;
    bi  = (pc / 4) % 16;
    st  = m_pht[pi];
    hit = m_bv[bi] && (m_btag[bi] == pc / 64);
    tk  = hit && (st >= 2);
    tgt = tk ? m_btgt[bi] : (pc - (pc % 4)) + 32'd4;
    return {1'b1, tk, st[1:0], hit, tgt};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) m_pht[i] = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
      m_exp = '0;
    end else begin
      // Applying writes before the read models write-first semantics.
      if (pht_we) m_pht[(pht_pc / 4) % 64] = int'(pht_state);
      if (btb_we) begin
        m_bv[(btb_pc / 4) % 16]   = 1'b1;
        m_btag[(btb_pc / 4) % 16] = btb_pc / 64;
        m_btgt[(btb_pc / 4) % 16] = btb_pc == btb_pc ? btb_target : btb_target;
      end
      if (!fs_stall) m_exp = fs_lookup_valid ? predict(fs_lookup_pc) : 37'h0;
    end
    m_live = 1'b1;
  end

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("model bp_info", bp_info, m_exp);
      check("model fields", {predict_valid, predict_taken, predict_state, btb_hit, predict_target}, m_exp);
    end
  end

  task automatic idle_inputs();
    fs_lookup_valid = 1'b0; fs_lookup_pc = '0; fs_stall = 1'b0;
    pht_we = 1'b0; pht_pc = '0; pht_state = '0;
    btb_we = 1'b0; btb_pc = '0; btb_target = '0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    fs_lookup_valid = 1'b1; fs_lookup_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [36:0] held;

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    check("reset bp_info", bp_info, 37'h0);
    tick();
    reset = 1'b0;

    // Cold lookup: weak-NT, no BTB entry, fall-through target
    lookup(32'h1C000000);
    tick();
    check("cold lookup", bp_info, {1'b1, 1'b0, 2'b01, 1'b0, 32'h1C000004});

    // Train 0x1C000010 without a lookup
    idle_inputs();
    btb_we = 1'b1; btb_pc = 32'h1C000010; btb_target = 32'h1C000100;
    pht_we = 1'b1; pht_pc = 32'h1C000010; pht_state = 2'b11;
    tick();
    check("no-lookup zeros", bp_info, 37'h0);
    idle_inputs();
    lookup(32'h1C000010);
    tick();
    check("trained hit", bp_info, {1'b1, 1'b1, 2'b11, 1'b1, 32'h1C000100});

    // Same-cycle write and lookup
    idle_inputs();
    btb_we = 1'b1; btb_pc = 32'h1C000020; btb_target = 32'h1C000200;
    pht_we = 1'b1; pht_pc = 32'h1C000020; pht_state = 2'b10;
    lookup(32'h1C000020);
    tick();
    check("bypass", bp_info, {1'b1, 1'b1, 2'b10, 1'b1, 32'h1C000200});

    // Alias in BTB index 4 with different tag; PHT forced strong-T via bypass
    idle_inputs();
    pht_we = 1'b1; pht_pc = 32'h1C000050; pht_state = 2'b11;
    lookup(32'h1C000050);
    tick();
    check("alias miss", bp_info, {1'b1, 1'b0, 2'b11, 1'b0, 32'h1C000054});

    // Stall hold while PC changes and tables are written
    idle_inputs();
    lookup(32'h1C000000);
    tick();
    held = {1'b1, 1'b0, 2'b01, 1'b0, 32'h1C000004};
    check("pre-stall", bp_info, held);
    fs_stall = 1'b1;
    pht_we = 1'b1; pht_pc = 32'h1C000040; pht_state = 2'b10;
    btb_we = 1'b1; btb_pc = 32'h1C000040; btb_target = 32'h1C000400;
    lookup(32'h1C000040);
    tick();
    check("stall hold 1", bp_info, held);
    pht_we = 1'b0; btb_we = 1'b0;
    lookup(32'h1C000080);
    tick();
    check("stall hold 2", bp_info, held);
    lookup(32'h1C000010);
    tick();
    check("stall hold 3", bp_info, held);
    fs_stall = 1'b0;
    lookup(32'h1C000040);
    tick();
    check("post-stall", bp_info, {1'b1, 1'b1, 2'b10, 1'b1, 32'h1C000400});

    // Reset wins over a simultaneous write and lookup
    reset = 1'b1;
    pht_we = 1'b1; pht_pc = 32'h1C000010; pht_state = 2'b11;
    lookup(32'h1C000010);
    tick();
    check("mid reset", bp_info, 37'h0);
    reset = 1'b0;
    idle_inputs();
    lookup(32'h1C000010);
    tick();
    check("after reset", bp_info, {1'b1, 1'b0, 2'b01, 1'b0, 32'h1C000014});
    lookup(32'hFFFFFFFC);
    tick();
    check("wrap target", bp_info, {1'b1, 1'b0, 2'b01, 1'b0, 32'h00000000});
    lookup(32'h1C000027);
    tick();
    check("low bits ignored", bp_info, {1'b1, 1'b0, 2'b01, 1'b0, 32'h1C000028});

    // Mixed traffic on a small PC pool, checked by the model each cycle
    for (int i = 0; i < 60; i++) begin
      idle_inputs();
      fs_stall   = (i % 9) == 4;
      pht_we     = (i % 3) != 0;
      pht_pc     = 32'h1C000000 + 32'((i * 20) % 256);
      pht_state  = 2'(i * 7);
      btb_we     = (i % 4) != 1;
      btb_pc     = 32'h1C000000 + 32'((i * 44) % 512);
      btb_target = 32'h2000_0000 + 32'(i * 16);
      fs_lookup_valid = (i % 7) != 3;
      fs_lookup_pc    = (i % 5 == 0) ? btb_pc : 32'h1C000000 + 32'((i * 12) % 512);
      tick();
    end

    idle_inputs();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
